// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared state encoding and sizing helpers for the tick scheduler.
package tick_sched_pkg;
   typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_e;
   localparam int CW_DEF = 24;
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/tick_sched_chan.sv
// tick_sched_chan: one tick channel; a shadow period is promoted only at terminal count,
// so reprogramming never shortens the period already in flight.
module tick_sched_chan
   import tick_sched_pkg::*;
#(
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          aln,
   input  logic          syn,
   input  logic          run,
   input  logic          wr_idle,
   input  logic          wr_run,
   input  logic [CW-1:0] cfg_div,
   output logic          tick,
   output logic          sq
);
   logic [CW-1:0] cnt_q, cnt_d, act_q, act_d, sh_q, sh_d, div;
   logic          pend_q, pend_d, sq_q, sq_d, tc;

   function automatic logic [CW-1:0] less1(input logic [CW-1:0] x);
      return (x == '0) ? '0 : x - CW'(1);
   endfunction

   assign div  = pend_q ? sh_q : act_q;
   assign tc   = cnt_q == '0;
   assign tick = run & ~syn & (act_q != '0) & tc;
   assign sq   = sq_q;

   always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      sh_d   = sh_q;
      pend_d = pend_q;
      sq_d   = sq_q;
      if (clr) begin
         cnt_d  = '0;
         act_d  = div;
         pend_d = 1'b0;
         sq_d   = 1'b0;
      end else if (aln) begin
         cnt_d = less1(act_q);
         sq_d  = 1'b0;
      end else if (syn) begin
         cnt_d  = less1(div);
         act_d  = div;
         pend_d = 1'b0;
         sq_d   = 1'b0;
      end else if (run) begin
         cnt_d  = tc ? less1(div) : cnt_q - CW'(1);
         act_d  = tc ? div : act_q;
         pend_d = tc ? 1'b0 : pend_q;
         sq_d   = sq_q ^ tick;
      end
      // a write lands after any same-cycle reload, so the reload sees pre-write values
      if (wr_idle) begin
         act_d  = cfg_div;
         pend_d = 1'b0;
      end
      if (wr_run) begin
         sh_d   = cfg_div;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         act_q  <= '0;
         sh_q   <= '0;
         pend_q <= 1'b0;
         sq_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         sh_q   <= sh_d;
         pend_q <= pend_d;
         sq_q   <= sq_d;
      end
   end
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: multi-channel clock-enable scheduler; shared IDLE/ALIGN/RUN control
// plus config decode driving one tick_sched_chan per channel.
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = CW_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   sync,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [ch_w(NCH)-1:0]   cfg_ch,
   input  logic [CW-1:0]          cfg_div,
   output logic [NCH-1:0]         tick,
   output logic [NCH-1:0]         sq,
   output logic                   running
);
   localparam int CHW = ch_w(NCH);
   state_e state_q, state_d;
   logic   running_q, cfg_ready_q, is_idle, is_run, acc, aln, syn;

   assign is_idle   = state_q == IDLE;
   assign is_run    = state_q == RUN;
   assign acc       = cfg_valid & cfg_ready_q;
   assign aln       = ~stop & (state_q == ALIGN);
   assign syn       = ~stop & is_run & sync;
   assign running   = running_q;
   assign cfg_ready = cfg_ready_q;

   always_comb state_d = stop ? IDLE : (is_idle && start) ? ALIGN : (state_q == ALIGN) ? RUN : state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         running_q   <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         running_q   <= state_d == RUN;
         cfg_ready_q <= state_d != ALIGN;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      tick_sched_chan #(.CW(CW)) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (stop),
         .aln     (aln),
         .syn     (syn),
         .run     (is_run),
         .wr_idle (acc && is_idle && cfg_ch == CHW'(i)),
         .wr_run  (acc && is_run && cfg_ch == CHW'(i)),
         .cfg_div (cfg_div),
         .tick    (tick[i]),
         .sq      (sq[i])
      );
   end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: randomized and directed stimulus against a timestamp-based schedule
// model; expectations are queued per cycle and checked by an independent monitor.
module tb_tick_scheduler;
   localparam int NCH = 4;
   localparam int CW  = 24;

   logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, sync = 1'b0;
   logic           cfg_valid = 1'b0, cfg_ready, running;
   logic [1:0]     cfg_ch = '0;
   logic [CW-1:0]  cfg_div = '0;
   logic [NCH-1:0] tick, sq;

   always #5 clk = ~clk;

   tick_scheduler #(.NCH(NCH), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .sync      (sync),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .tick      (tick),
      .sq        (sq),
      .running   (running)
   );

   typedef struct packed {
      logic [NCH-1:0] tick;
      logic [NCH-1:0] sq;
      logic           running;
      logic           ready;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0, n_bad = 0;

   // model: mode 0 idle / 1 align / 2 run; each channel knows the absolute cycle of its next terminal count
   int mode, cyc;
   int per[NCH], pendv[NCH], next_at[NCH];
   bit sqm[NCH];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, want);
      end
   endtask

   function automatic int span(input int p);
      return (p > 0) ? p : 1;
   endfunction

   task automatic model_reset();
      mode = 0;
      for (int c = 0; c < NCH; c++) begin
         per[c] = 0;
         pendv[c] = -1;
         next_at[c] = 0;
         sqm[c] = 1'b0;
      end
   endtask

   task automatic step(input bit st, input bit sp, input bit sy, input bit cv, input int ch, input int dv);
      exp_t e;
      bit   syn, acc;
      int   old_mode;
      @(posedge clk);
      #1;
      rst_n = 1'b1; start = st; stop = sp; sync = sy; cfg_valid = cv;
      cfg_ch = 2'(ch); cfg_div = CW'(dv);
      syn = sy && !sp && mode == 2;
      acc = cv && mode != 1;
      e.running = mode == 2;
      e.ready = mode != 1;
      for (int c = 0; c < NCH; c++) begin
         e.tick[c] = mode == 2 && !syn && per[c] != 0 && cyc == next_at[c];
         e.sq[c] = sqm[c];
      end
      exp_q.push_back(e);
      old_mode = mode;
      if (sp) begin
         for (int c = 0; c < NCH; c++) begin
            if (pendv[c] >= 0) per[c] = pendv[c];
            pendv[c] = -1;
            sqm[c] = 1'b0;
         end
         mode = 0;
      end else if (mode == 0) begin
         if (st) mode = 1;
      end else if (mode == 1) begin
         for (int c = 0; c < NCH; c++) begin
            next_at[c] = cyc + span(per[c]);
            sqm[c] = 1'b0;
         end
         mode = 2;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (!syn && e.tick[c]) sqm[c] = ~sqm[c];
            if (syn || cyc == next_at[c]) begin
               if (pendv[c] >= 0) per[c] = pendv[c];
               pendv[c] = -1;
               next_at[c] = cyc + span(per[c]);
            end
            if (syn) sqm[c] = 1'b0;
         end
      end
      if (acc && old_mode == 0) begin
         per[ch] = dv;
         pendv[ch] = -1;
      end else if (acc) pendv[ch] = dv;
      cyc++;
   endtask

   task automatic run_n(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
      #1;
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_sq", 32'(sq), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      model_reset();
      e.tick = '0;
      e.sq = '0;
      e.running = 1'b0;
      e.ready = 1'b1;
      exp_q.push_back(e);
      cyc++;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("tick", 32'(tick), 32'(e.tick));
         chk("sq", 32'(sq), 32'(e.sq));
         chk("running", 32'(running), 32'(e.running));
         chk("cfg_ready", 32'(cfg_ready), 32'(e.ready));
      end
   end

   initial begin
      int k, r, dv;
      bit sp;
      model_reset();
      cyc = 0;
      repeat (3) @(posedge clk);
      do_reset();
      step(0, 0, 0, 1, 0, 4);
      step(0, 0, 0, 1, 1, 1);
      step(1, 0, 0, 0, 0, 0);
      run_n(20);
      step(0, 0, 0, 1, 0, 6);
      run_n(30);
      k = 0;
      while (!(mode == 2 && cyc == next_at[0] && per[0] != 0) && k < 50) begin
         step(0, 0, 0, 0, 0, 0);
         k++;
      end
      step(0, 0, 0, 1, 0, 2);
      run_n(20);
      step(0, 0, 0, 1, 2, 5);
      run_n(15);
      step(0, 0, 0, 1, 2, 0);
      run_n(15);
      step(0, 0, 0, 1, 2, 3);
      run_n(12);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 3);
      step(0, 0, 0, 1, 1, 7);
      step(0, 0, 0, 1, 2, 0);
      step(0, 0, 0, 1, 3, 24'hFFFFFF);
      step(1, 0, 0, 0, 0, 0);
      run_n(4);
      step(0, 0, 1, 0, 0, 0);
      run_n(25);
      step(0, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      run_n(3);
      step(1, 0, 0, 0, 0, 0);
      run_n(6);
      step(0, 1, 0, 0, 0, 0);
      run_n(2);
      step(1, 0, 0, 0, 0, 0);
      run_n(8);
      do_reset();
      run_n(3);
      repeat (3000) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         else begin
            sp = $urandom_range(0, 63) == 0;
            r = $urandom_range(0, 15);
            dv = (r < 14) ? r % 9 : $urandom_range(9, 20);
            step($urandom_range(0, 15) == 0, sp, $urandom_range(0, 31) == 0,
                 !sp && $urandom_range(0, 2) == 0, $urandom_range(0, 3), dv);
         end
      end
      @(negedge clk);
      @(negedge clk);
      chk("queue_drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
